vector_command_scheduler: RTL and testbench



---
 rtl/vector_cmd_pkg.sv | 46 ++++
 rtl/cmd_watchdog.sv | 26 ++
 rtl/vector_command_scheduler.sv | 133 +++++++++++++
 tb/tb_vector_command_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_cmd_pkg.sv
// Shared command codes, result encodings and FSM state type for vector_command_scheduler.
package vector_cmd_pkg;

  localparam logic [7:0] CMD_LOAD_A   = 8'h01;
  localparam logic [7:0] CMD_LOAD_B   = 8'h02;
  localparam logic [7:0] CMD_READ_A   = 8'h03;
  localparam logic [7:0] CMD_READ_B   = 8'h04;
  localparam logic [7:0] CMD_SUM      = 8'h05;
  localparam logic [7:0] CMD_AVG      = 8'h06;
  localparam logic [7:0] CMD_EUC_DIST = 8'h07;
  localparam logic [7:0] CMD_MAN_DIST = 8'h08;

  // result[3] strobe, result[2] vector(1)/scalar(0), result[1:0] op
  localparam int unsigned RES_STROBE   = 3;
  localparam logic [3:0]  RES_READ_A   = 4'b1100;
  localparam logic [3:0]  RES_READ_B   = 4'b1101;
  localparam logic [3:0]  RES_SUM      = 4'b1110;
  localparam logic [3:0]  RES_AVG      = 4'b1111;
  localparam logic [3:0]  RES_EUC_DIST = 4'b1000;
  localparam logic [3:0]  RES_MAN_DIST = 4'b1001;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WAIT_DONE
  } sched_state_t;

  // Maps an execute command byte to its result encoding; zero for anything else.
  function automatic logic [3:0] cmd_result(input logic [7:0] cmd);
    logic [3:0] res;
    res = '0;
    case (cmd)
      CMD_READ_A:   res = RES_READ_A;
      CMD_READ_B:   res = RES_READ_B;
      CMD_SUM:      res = RES_SUM;
      CMD_AVG:      res = RES_AVG;
      CMD_EUC_DIST: res = RES_EUC_DIST;
      CMD_MAN_DIST: res = RES_MAN_DIST;
      default:      res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Load watchdog: counts idle cycles while not cleared and flags LIMIT-1 reached.
module cmd_watchdog #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] count;

  assign expired = (count == W'(LIMIT - 1));

  // Saturates at the terminal count so the flag stays up until cleared.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vector_command_scheduler.sv
// UART command decoder and vector load sequencer for the vector processing block.
// Optional load watchdog enabled with `define CMD_TIMEOUT_EN.
module vector_command_scheduler
  import vector_cmd_pkg::*;
#(
  parameter int unsigned NBytes         = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  input  logic       done,
  output logic [3:0] result,
  output logic       bramA_we,
  output logic       bramB_we,
  output logic [9:0] write_addr,
  output logic [7:0] write_data,
  output logic       busy,
  output logic       load_done,
  output logic       cmd_error
);

  localparam logic [9:0] LAST_ADDR = 10'(NBytes - 1);

  if (NBytes < 2 || NBytes > 1024 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("vector_command_scheduler: parameter out of range");
  end

  sched_state_t state;
  logic [9:0]   byte_cnt;
  logic         wd_expired;
  logic         in_load;

  assign in_load = (state == LOAD_A) || (state == LOAD_B);

`ifdef CMD_TIMEOUT_EN
  // Held clear outside the load states, so it only ever times out a stalled load.
  cmd_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_ready || !in_load),
    .expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      result     <= '0;
      bramA_we   <= 1'b0;
      bramB_we   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      cmd_error  <= 1'b0;
    end else begin
      result    <= '0;
      bramA_we  <= 1'b0;
      bramB_we  <= 1'b0;
      load_done <= 1'b0;
      cmd_error <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_ready) begin
            case (rx_data)
              CMD_LOAD_A: begin
                state    <= LOAD_A;
                byte_cnt <= '0;
                busy     <= 1'b1;
              end
              CMD_LOAD_B: begin
                state    <= LOAD_B;
                byte_cnt <= '0;
                busy     <= 1'b1;
              end
              CMD_READ_A, CMD_READ_B, CMD_SUM, CMD_AVG, CMD_EUC_DIST, CMD_MAN_DIST: begin
                result <= cmd_result(rx_data);
                state  <= EXEC;
                busy   <= 1'b1;
              end
              default: cmd_error <= 1'b1;
            endcase
          end
        end

        LOAD_A, LOAD_B: begin
          if (rx_ready) begin
            bramA_we   <= in_load && (state == LOAD_A);
            bramB_we   <= in_load && (state == LOAD_B);
            write_addr <= byte_cnt;
            write_data <= rx_data;
            if (byte_cnt == LAST_ADDR) begin
              load_done <= 1'b1;
              state     <= IDLE;
              busy      <= 1'b0;
              byte_cnt  <= '0;
            end else begin
              byte_cnt <= byte_cnt + 10'd1;
            end
          end else if (wd_expired) begin
            cmd_error <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
            byte_cnt  <= '0;
          end
        end

        EXEC: state <= WAIT_DONE;

        WAIT_DONE: begin
          if (done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_command_scheduler.sv
// Self-checking bench for vector_command_scheduler (NBytes=4, TIMEOUT_CYCLES=16).
// Honours CMD_TIMEOUT_EN to expect either a watchdog abort or an indefinitely stalled load.
module tb_vector_command_scheduler;

  localparam int unsigned NB = 4;
  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       done;
  logic [3:0] result;
  logic       bramA_we;
  logic       bramB_we;
  logic [9:0] write_addr;
  logic [7:0] write_data;
  logic       busy;
  logic       load_done;
  logic       cmd_error;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 0 idle, 1 loading A, 2 loading B, 3 command outstanding
  int         mode   = 0;
  int         idx    = 0;
  int         silent = 0;
  logic [7:0] mem_a [NB];
  logic [7:0] mem_b [NB];
  logic [7:0] cap_a [1024];
  logic [7:0] cap_b [1024];

  vector_command_scheduler #(
    .NBytes        (NB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .done      (done),
    .result    (result),
    .bramA_we  (bramA_we),
    .bramB_we  (bramB_we),
    .write_addr(write_addr),
    .write_data(write_data),
    .busy      (busy),
    .load_done (load_done),
    .cmd_error (cmd_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_res(input logic [7:0] b);
    case (b)
      8'h03:   return 4'hC;
      8'h04:   return 4'hD;
      8'h05:   return 4'hE;
      8'h06:   return 4'hF;
      8'h07:   return 4'h8;
      8'h08:   return 4'h9;
      default: return 4'h0;
    endcase
  endfunction

  task automatic expect_cycle(input logic [3:0] er, input logic ea, input logic eb,
                              input logic [9:0] eaddr, input logic [7:0] edata,
                              input logic eld, input logic eerr, input logic ebusy);
    chk("result", 32'(result), 32'(er));
    chk("bramA_we", 32'(bramA_we), 32'(ea));
    chk("bramB_we", 32'(bramB_we), 32'(eb));
    if (ea || eb) begin
      chk("write_addr", 32'(write_addr), 32'(eaddr));
      chk("write_data", 32'(write_data), 32'(edata));
    end
    chk("load_done", 32'(load_done), 32'(eld));
    chk("cmd_error", 32'(cmd_error), 32'(eerr));
    chk("busy", 32'(busy), 32'(ebusy));
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] er;
    logic       ea, eb, eld, eerr;
    logic [9:0] eaddr;
    er = '0; ea = 1'b0; eb = 1'b0; eld = 1'b0; eerr = 1'b0; eaddr = '0;
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    case (mode)
      0: begin
        if (b == 8'h01 || b == 8'h02) begin
          mode = int'(b);
          idx = 0;
          silent = 0;
        end else if (b >= 8'h03 && b <= 8'h08) begin
          er = exp_res(b);
          mode = 3;
        end else begin
          eerr = 1'b1;
        end
      end
      1, 2: begin
        ea = (mode == 1);
        eb = (mode == 2);
        eaddr = 10'(idx);
        if (mode == 1) mem_a[idx] = b;
        else mem_b[idx] = b;
        silent = 0;
        if (idx == NB - 1) begin
          eld = 1'b1;
          mode = 0;
          idx = 0;
        end else begin
          idx++;
        end
      end
      default: ;
    endcase
    expect_cycle(er, ea, eb, eaddr, b, eld, eerr, mode != 0);
  endtask

  task automatic idle_cycles(input int n);
    logic eerr;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      eerr = 1'b0;
`ifdef CMD_TIMEOUT_EN
      if (mode == 1 || mode == 2) begin
        silent++;
        if (silent == TO) begin
          eerr = 1'b1;
          mode = 0;
          idx = 0;
        end
      end
`endif
      expect_cycle(4'h0, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, eerr, mode != 0);
    end
  endtask

  task automatic done_pulse(input logic with_byte, input logic [7:0] b);
    done = 1'b1;
    rx_ready = with_byte;
    rx_data = b;
    @(posedge clk);
    #1;
    done = 1'b0;
    rx_ready = 1'b0;
    if (mode == 3) mode = 0;
    expect_cycle(4'h0, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, mode != 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mode = 0;
    idx = 0;
    expect_cycle(4'h0, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
  endtask

  // BRAM image as seen through the write ports, plus the one-hot write enable rule.
  always @(negedge clk) begin
    if (!reset) begin
      if (bramA_we) cap_a[write_addr] = write_data;
      if (bramB_we) cap_b[write_addr] = write_data;
      if (bramA_we || bramB_we) chk("we_onehot", 32'(bramA_we && bramB_we), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    logic [7:0] b;
    int         r;
    reset = 1'b1;
    rx_ready = 1'b0;
    rx_data = '0;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_cycle(4'h0, 1'b0, 1'b0, 10'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_write_data", 32'(write_data), 32'd0);
    reset = 1'b0;

    // Load A
    send_byte(8'h01);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    idle_cycles(2);

    // SUM with a dropped byte while outstanding
    send_byte(8'h05);
    idle_cycles(2);
    send_byte(8'h06);
    idle_cycles(2);
    done_pulse(1'b0, 8'h00);
    idle_cycles(1);

    // Scalar commands
    send_byte(8'h08);
    idle_cycles(3);
    done_pulse(1'b0, 8'h00);
    idle_cycles(1);
    send_byte(8'h07);
    idle_cycles(2);
    done_pulse(1'b0, 8'h00);

    // Unknown codes
    send_byte(8'h00);
    send_byte(8'hFF);
    idle_cycles(1);

    // Reset in the middle of a B load, then a full B load
    send_byte(8'h02);
    send_byte(8'hAA);
    send_byte(8'hBB);
    pulse_reset();
    send_byte(8'h02);
    for (int i = 0; i < NB; i++) send_byte(8'(8'h50 + i));
    idle_cycles(1);

    // Byte arriving together with done is dropped; next cycle accepts
    send_byte(8'h03);
    idle_cycles(2);
    done_pulse(1'b1, 8'h05);
    send_byte(8'h04);
    idle_cycles(2);
    done_pulse(1'b0, 8'h00);

    // Stalled load
    send_byte(8'h01);
    send_byte(8'h10);
`ifdef CMD_TIMEOUT_EN
    idle_cycles(TO);
    send_byte(8'h03);
    idle_cycles(2);
    done_pulse(1'b0, 8'h00);
`else
    idle_cycles(TO + 4);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
`endif
    idle_cycles(1);

    // Randomised traffic
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        send_byte(r == 0 ? 8'h01 : 8'h02);
        for (int k = 0; k < NB; k++) begin
          idle_cycles(int'($urandom_range(0, 3)));
          send_byte(8'($urandom));
        end
      end else if (r < 8) begin
        send_byte(8'($urandom_range(3, 8)));
        idle_cycles(int'($urandom_range(1, 4)));
        if ($urandom_range(0, 1) == 1) begin
          send_byte(8'($urandom));
          idle_cycles(1);
        end
        done_pulse($urandom_range(0, 1) == 1, 8'($urandom_range(1, 8)));
      end else begin
        b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(9, 255)) : 8'h00;
        send_byte(b);
      end
      idle_cycles(int'($urandom_range(0, 2)));
    end
    idle_cycles(2);

    for (int i = 0; i < NB; i++) begin
      chk("bram_a", 32'(cap_a[i]), 32'(mem_a[i]));
      chk("bram_b", 32'(cap_b[i]), 32'(mem_b[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
